dtc_train_tx: RTL

DTC_TRAIN_TX -- requirements
Module: dtc_train_tx

---
 rtl/dtc_tx_pkg.sv | 16 +
 rtl/prbs15_gen.sv | 42 ++++
 rtl/dtc_train_tx.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dtc_tx_pkg.sv
// Shared state encoding and fixed words for the DTC readout transmitter.
package dtc_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAIN = 2'd1,
        DATA  = 2'd2,
        TRLR  = 2'd3
    } state_t;

    localparam logic [15:0] IDLE_WORD = 16'h00FF;
    localparam logic [15:0] HDR_WORD  = 16'hA5C3;
    localparam logic [3:0]  TRLR_TAG  = 4'hE;
    localparam logic [14:0] PRBS_SEED = 15'h7FFF;

endpackage

// File: rtl/prbs15_gen.sv
// PRBS-15 (x^15+x^14+1) word source, 16 bits per cycle; only built with DTC_TX_PRBS_EN.
// o_word is combinational from the seed (i_load) or current LFSR; i_adv steps the LFSR 16 bits.
`ifdef DTC_TX_PRBS_EN
module prbs15_gen
    import dtc_tx_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_adv,
    output logic [15:0] o_word
);
    logic [14:0] r_lfsr;
    logic [14:0] w_lfsr_nxt;
    logic [15:0] w_word;
    logic        w_fb;

    always_comb begin
        w_lfsr_nxt = i_load ? PRBS_SEED : r_lfsr;
        w_word     = '0;
        w_fb       = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w_fb       = w_lfsr_nxt[14] ^ w_lfsr_nxt[13];
            w_word     = {w_word[14:0], w_fb};
            w_lfsr_nxt = {w_lfsr_nxt[13:0], w_fb};
        end
    end

    assign o_word = w_word;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= PRBS_SEED;
        end else if (i_adv) begin
            r_lfsr <= w_lfsr_nxt;
        end else if (i_load) begin
            r_lfsr <= PRBS_SEED;
        end
    end

endmodule
`endif

// File: rtl/dtc_train_tx.sv
// DTC readout word transmitter: training bursts (PRBS-15 words when DTC_TX_PRBS_EN) and framed payload.
// ser_dout registered one rdoclk after selection; payload_ready is high only in DATA, fill word sent on gaps.
module dtc_train_tx
    import dtc_tx_pkg::*;
#(
    parameter logic [15:0] TRAIN_WORD = 16'hF0F0,
    parameter logic [15:0] FILL_WORD  = 16'h7F7F
) (
    input  logic        rdoclk,
    input  logic        RegFsmRst,
    input  logic        train_req,
    input  logic [15:0] train_len,
    input  logic        payload_valid,
    input  logic [15:0] payload_data,
    input  logic        payload_last,
    output logic        payload_ready,
    output logic [15:0] ser_dout,
    output logic        train_busy,
    output logic        train_done
);
    state_t      r_state, w_state_nxt;
    logic [15:0] r_dout, w_dout_nxt;
    logic [15:0] r_train_rem, w_train_rem_nxt;
    logic [11:0] r_word_cnt, w_word_cnt_nxt;
    logic        r_train_pending, w_train_pending_nxt;
    logic        r_train_done, w_train_done_nxt;
    logic        r_trlr_gap;
    logic [15:0] w_train_word;

`ifdef DTC_TX_PRBS_EN
    // Seed is reapplied every IDLE cycle so the word chosen on TRAIN entry is always the first of the sequence.
    logic w_prbs_load;
    logic w_prbs_adv;
    assign w_prbs_load = (r_state == IDLE);
    assign w_prbs_adv  = (r_state == IDLE) || (r_state == TRAIN);

    prbs15_gen u_prbs15_gen (
        .i_clk  (rdoclk),
        .i_rst  (RegFsmRst),
        .i_load (w_prbs_load),
        .i_adv  (w_prbs_adv),
        .o_word (w_train_word)
    );
`else
    assign w_train_word = TRAIN_WORD;
`endif

    assign payload_ready = (r_state == DATA);
    assign train_busy    = (r_state == TRAIN);
    assign train_done    = r_train_done;
    assign ser_dout      = r_dout;

    always_comb begin
        w_state_nxt         = r_state;
        w_dout_nxt          = IDLE_WORD;
        w_train_rem_nxt     = r_train_rem;
        w_word_cnt_nxt      = r_word_cnt;
        w_train_pending_nxt = r_train_pending;
        w_train_done_nxt    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (train_req || r_train_pending) begin
                    w_state_nxt         = TRAIN;
                    w_dout_nxt          = w_train_word;
                    w_train_rem_nxt     = (train_len == 16'd0) ? 16'd1 : train_len;
                    w_train_pending_nxt = 1'b0;
                end else if (payload_valid && !r_trlr_gap) begin
                    // The cycle right after a trailer still shows the trailer, so a header waits one more.
                    w_state_nxt    = DATA;
                    w_dout_nxt     = HDR_WORD;
                    w_word_cnt_nxt = '0;
                end
            end
            TRAIN: begin
                if (r_train_rem <= 16'd1) begin
                    w_state_nxt      = IDLE;
                    w_train_done_nxt = 1'b1;
                end else begin
                    w_dout_nxt      = w_train_word;
                    w_train_rem_nxt = r_train_rem - 16'd1;
                end
            end
            DATA: begin
                if (train_req) w_train_pending_nxt = 1'b1;
                if (payload_valid) begin
                    w_dout_nxt     = payload_data;
                    w_word_cnt_nxt = r_word_cnt + 12'd1;
                    if (payload_last) w_state_nxt = TRLR;
                end else begin
                    w_dout_nxt = FILL_WORD;
                end
            end
            TRLR: begin
                if (train_req) w_train_pending_nxt = 1'b1;
                w_dout_nxt  = {TRLR_TAG, r_word_cnt};
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rdoclk) begin
        if (RegFsmRst) begin
            r_state         <= IDLE;
            r_dout          <= IDLE_WORD;
            r_train_rem     <= '0;
            r_word_cnt      <= '0;
            r_train_pending <= 1'b0;
            r_train_done    <= 1'b0;
            r_trlr_gap      <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_dout          <= w_dout_nxt;
            r_train_rem     <= w_train_rem_nxt;
            r_word_cnt      <= w_word_cnt_nxt;
            r_train_pending <= w_train_pending_nxt;
            r_train_done    <= w_train_done_nxt;
            r_trlr_gap      <= (r_state == TRLR);
        end
    end

endmodule
